// File: rtl/mem_access.sv
// MEM stage and MEM/WB register: runs one data-memory req/ack transaction at a time.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned H/W accesses and flags addr_err.
module mem_access #(
    parameter int W          = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SRC_W      = 2,
    parameter int DST_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_mem_op,
    input  logic [W-1:0]          in_alu_result,
    input  logic [W-1:0]          in_store_data,
    input  logic [W-1:0]          in_pc,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [REG_ADDR_W-1:0] in_rt,
    input  logic [SRC_W-1:0]      in_reg_write_src,
    input  logic [DST_W-1:0]      in_reg_write_dst,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [W-1:0]          dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [W-1:0]          dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [W-1:0]          dmem_rdata,
    output logic                  out_valid,
    output logic                  out_reg_write,
    output logic [W-1:0]          out_alu_result,
    output logic [W-1:0]          out_mem_data,
    output logic [W-1:0]          out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [SRC_W-1:0]      out_reg_write_src,
    output logic [DST_W-1:0]      out_reg_write_dst,
    output logic                  addr_err,
    output logic                  state_dbg
);

    // Handshake: dmem_req/we/addr/be/wdata stay stable from the request edge until the
    // cycle dmem_ack is high; that cycle completes the transfer and dmem_rdata is valid.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t state, state_next;

    logic                  mem_op, is_byte, is_half, misaligned;
    logic [3:0]            be_calc;
    logic [W-1:0]          wdata_calc;
    logic [2:0]            op_q;
    logic [1:0]            lane_q;
    logic [W-1:0]          alu_q, pc_q;
    logic                  rw_q;
    logic [REG_ADDR_W-1:0] rd_q, rt_q;
    logic [SRC_W-1:0]      src_q;
    logic [DST_W-1:0]      dst_q;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [W-1:0]          load_data;

    assign mem_op  = in_valid & (in_mem_read | in_mem_write);
    assign is_byte = (in_mem_op == 3'd0) | (in_mem_op == 3'd1);
    assign is_half = (in_mem_op == 3'd2) | (in_mem_op == 3'd3);
    assign state_dbg = (state == BUSY);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & ((is_half & in_alu_result[0]) |
                                  (!is_byte && !is_half && (in_alu_result[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = in_store_data;
        if (is_byte) begin
            be_calc    = 4'b0001 << in_alu_result[1:0];
            wdata_calc = {(W/8){in_store_data[7:0]}};
        end else if (is_half) begin
            be_calc    = in_alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {(W/16){in_store_data[15:0]}};
        end
    end

    always_comb begin
        byte_lane = dmem_rdata[7:0];
        case (lane_q)
            2'd1:    byte_lane = dmem_rdata[15:8];
            2'd2:    byte_lane = dmem_rdata[23:16];
            2'd3:    byte_lane = dmem_rdata[31:24];
            default: byte_lane = dmem_rdata[7:0];
        endcase
        half_lane = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            3'd0:    load_data = {{(W-8){byte_lane[7]}}, byte_lane};
            3'd1:    load_data = {{(W-8){1'b0}}, byte_lane};
            3'd2:    load_data = {{(W-16){half_lane[15]}}, half_lane};
            3'd3:    load_data = {{(W-16){1'b0}}, half_lane};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: if (mem_op && !misaligned) begin
                state_next = BUSY;
                stall      = 1'b1;
            end
            BUSY: if (dmem_ack) state_next = IDLE;
                  else          stall      = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_addr <= '0; dmem_be <= 4'b0; dmem_wdata <= '0;
            op_q <= 3'd0; lane_q <= 2'd0; alu_q <= '0; pc_q <= '0; rw_q <= 1'b0;
            rd_q <= '0; rt_q <= '0; src_q <= '0; dst_q <= '0;
            out_valid <= 1'b0; out_reg_write <= 1'b0; out_alu_result <= '0; out_mem_data <= '0;
            out_pc <= '0; out_rd <= '0; out_rt <= '0; out_reg_write_src <= '0;
            out_reg_write_dst <= '0; addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: if (mem_op && !misaligned) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= in_mem_write;
                    dmem_addr  <= {in_alu_result[W-1:2], 2'b00};
                    dmem_be    <= be_calc;
                    dmem_wdata <= wdata_calc;
                    op_q <= in_mem_op; lane_q <= in_alu_result[1:0];
                    alu_q <= in_alu_result; pc_q <= in_pc; rw_q <= in_reg_write;
                    rd_q <= in_rd; rt_q <= in_rt; src_q <= in_reg_write_src; dst_q <= in_reg_write_dst;
                    out_valid     <= 1'b0;
                    out_reg_write <= 1'b0;
                end else begin
                    // Pass-through slot; a rejected misaligned access retires without a write.
                    out_valid         <= in_valid;
                    out_reg_write     <= in_valid & in_reg_write & !misaligned;
                    out_alu_result    <= in_alu_result;
                    out_mem_data      <= '0;
                    out_pc            <= in_pc;
                    out_rd            <= in_rd;
                    out_rt            <= in_rt;
                    out_reg_write_src <= in_reg_write_src;
                    out_reg_write_dst <= in_reg_write_dst;
                    addr_err          <= misaligned;
                end
                BUSY: if (dmem_ack) begin
                    dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_be <= 4'b0;
                    out_valid         <= 1'b1;
                    out_reg_write     <= rw_q;
                    out_alu_result    <= alu_q;
                    out_mem_data      <= dmem_we ? '0 : load_data;
                    out_pc            <= pc_q;
                    out_rd            <= rd_q;
                    out_rt            <= rt_q;
                    out_reg_write_src <= src_q;
                    out_reg_write_dst <= dst_q;
                end else begin
                    out_valid     <= 1'b0;
                    out_reg_write <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: reference model feeds expected writeback and bus queues,
// a memory responder and a writeback monitor check the DUT independently of the driver.
module tb_mem_access;
    localparam int W  = 32;
    localparam int RA = 5;
    localparam int OW = 1 + W + W + W + RA + RA + 2 + 2 + 1;
    localparam int BW = 1 + W + 4 + W;

    logic          clk, rst;
    logic          in_valid, in_mem_read, in_mem_write, in_reg_write;
    logic [2:0]    in_mem_op;
    logic [W-1:0]  in_alu_result, in_store_data, in_pc;
    logic [RA-1:0] in_rd, in_rt;
    logic [1:0]    in_reg_write_src, in_reg_write_dst;
    logic          stall, dmem_req, dmem_we, dmem_ack;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_be;
    logic          out_valid, out_reg_write, addr_err, state_dbg;
    logic [W-1:0]  out_alu_result, out_mem_data, out_pc;
    logic [RA-1:0] out_rd, out_rt;
    logic [1:0]    out_reg_write_src, out_reg_write_dst;

    int tests = 0;
    int fails = 0;
    logic [OW-1:0] exp_q[$];
    logic [BW-1:0] bus_q[$];
    logic [W-1:0]  rdata_q[$];
    int            delay_q[$];
    bit            slave_en = 1'b1;
    bit            late_ack = 1'b0;

    mem_access dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_mem_op(in_mem_op), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_pc(in_pc), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_rt(in_rt), .in_reg_write_src(in_reg_write_src),
        .in_reg_write_dst(in_reg_write_dst), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
        .out_reg_write(out_reg_write), .out_alu_result(out_alu_result),
        .out_mem_data(out_mem_data), .out_pc(out_pc), .out_rd(out_rd), .out_rt(out_rt),
        .out_reg_write_src(out_reg_write_src), .out_reg_write_dst(out_reg_write_dst),
        .addr_err(addr_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] pack_out(logic rw, logic [W-1:0] alu, logic [W-1:0] md,
                                                logic [W-1:0] pc, logic [RA-1:0] rd, logic [RA-1:0] rt,
                                                logic [1:0] src, logic [1:0] dst, logic err);
        return {rw, alu, md, pc, rd, rt, src, dst, err};
    endfunction

    function automatic logic [BW-1:0] bus_vec(logic we, logic [W-1:0] a, logic [3:0] be, logic [W-1:0] wd);
        return {we, a, be, we ? wd : 32'h0};
    endfunction

    // scoreboard monitor: every retired writeback slot must match the oldest expectation
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got out_valid=1 alu=%h expected no retirement", out_alu_result);
            end else begin
                chk("wb_out", 128'(pack_out(out_reg_write, out_alu_result, out_mem_data, out_pc, out_rd,
                                            out_rt, out_reg_write_src, out_reg_write_dst, addr_err)),
                    128'(exp_q.pop_front()));
            end
        end
    end

    // data-memory responder: checks request fields, holds them stable, acks after a scripted delay
    initial begin : slave
        bit            in_txn;
        int            dly;
        logic [BW-1:0] cur;
        in_txn = 1'b0; dly = 0; cur = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (!slave_en) begin
                dmem_ack = late_ack;
            end else if (!rst) begin
                in_txn = 1'b0;
            end else if (dmem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    if (bus_q.size() == 0 || delay_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL bus_unexpected: got dmem_req addr=%h expected no request", dmem_addr);
                        dly = 0;
                        cur = bus_vec(dmem_we, dmem_addr, dmem_be, dmem_wdata);
                    end else begin
                        cur = bus_q.pop_front();
                        dly = delay_q.pop_front();
                        chk("bus_req", 128'(bus_vec(dmem_we, dmem_addr, dmem_be, dmem_wdata)), 128'(cur));
                    end
                end else begin
                    chk("bus_hold", 128'(bus_vec(dmem_we, dmem_addr, dmem_be, dmem_wdata)), 128'(cur));
                end
                if (dly == 0) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : $urandom;
                    in_txn     = 1'b0;
                end else begin
                    dly--;
                end
            end
        end
    end

    // driver + reference model; called at a negedge, returns at the negedge after acceptance
    task automatic drive_txn(input bit v, input bit rdn, input bit wrn, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] sd, input logic [W-1:0] pc,
                             input bit rw, input logic [RA-1:0] rd, input logic [RA-1:0] rt,
                             input logic [1:0] src, input logic [1:0] dst,
                             input logic [W-1:0] rdw, input int dly, input string name);
        int           sz, n_stall, exp_stall;
        bit           mem, mis, done;
        logic [31:0]  off, mask, val, wd;
        logic [3:0]   be4;
        sz   = (op <= 3'd1) ? 1 : (op <= 3'd3) ? 2 : 4;
        mem  = v && (rdn || wrn);
`ifdef MEM_ALIGN_CHECK_EN
        mis  = mem && ((a % sz) != 0);
`else
        mis  = 1'b0;
`endif
        off  = ((a % 4) / sz) * sz;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        be4  = 4'(((1 << sz) - 1) << off);
        wd   = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
               (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        val  = (rdw >> (8 * off)) & mask;
        if ((op == 3'd0 || op == 3'd2) && val[8*sz-1]) val = val | ~mask;

        if (v) begin
            if (mis)      exp_q.push_back(pack_out(1'b0, a, 32'h0, pc, rd, rt, src, dst, 1'b1));
            else if (mem) exp_q.push_back(pack_out(rw, a, wrn ? 32'h0 : val, pc, rd, rt, src, dst, 1'b0));
            else          exp_q.push_back(pack_out(rw, a, 32'h0, pc, rd, rt, src, dst, 1'b0));
        end
        if (mem && !mis) begin
            bus_q.push_back(bus_vec(wrn, a & ~32'd3, be4, wd));
            delay_q.push_back(dly);
            rdata_q.push_back(rdw);
        end
        exp_stall = (mem && !mis) ? 1 + dly : 0;

        in_valid = v; in_mem_read = rdn; in_mem_write = wrn; in_mem_op = op;
        in_alu_result = a; in_store_data = sd; in_pc = pc; in_reg_write = rw;
        in_rd = rd; in_rt = rt; in_reg_write_src = src; in_reg_write_dst = dst;

        n_stall = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            if (stall) n_stall++;
            else       done = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got stall held 20 cycles expected release", name);
        end else begin
            chk({name, "_stall"}, 128'(n_stall), 128'(exp_stall));
        end
    endtask

    initial begin
        // reset with a live mem op on the inputs
        rst = 1'b0; in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_mem_op = 3'd4;
        in_alu_result = 32'h40; in_store_data = 32'h5555_AAAA; in_pc = 32'h400; in_reg_write = 1'b1;
        in_rd = 5'd3; in_rt = 5'd4; in_reg_write_src = 2'd1; in_reg_write_dst = 2'd1;
        repeat (2) @(negedge clk);
        chk("reset_out", 128'({out_valid, out_reg_write, out_alu_result, out_mem_data, out_pc, out_rd,
                               out_rt, out_reg_write_src, out_reg_write_dst, addr_err}), 128'(0));
        chk("reset_bus", 128'({dmem_req, dmem_we, dmem_be, state_dbg}), 128'(0));
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);

        // directed: ALU op, LB/LBU at lane 3, SH upper half, LW at 0x6
        drive_txn(1, 0, 0, 3'd4, 32'h10, 32'h0, 32'h100, 1, 5'd5, 5'd0, 2'd0, 2'd0, 32'h0, 0, "alu");
        drive_txn(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h104, 1, 5'd0, 5'd8, 2'd1, 2'd1, 32'h80FF_FF7F, 3, "lb");
        drive_txn(1, 1, 0, 3'd1, 32'h103, 32'h0, 32'h108, 1, 5'd0, 5'd9, 2'd1, 2'd1, 32'h80FF_FF7F, 3, "lbu");
        drive_txn(1, 0, 1, 3'd2, 32'h22, 32'h1234_ABCD, 32'h10C, 0, 5'd0, 5'd2, 2'd0, 2'd1, 32'h0, 0, "sh");
        drive_txn(1, 1, 0, 3'd4, 32'h6, 32'h0, 32'h110, 1, 5'd0, 5'd7, 2'd1, 2'd1, 32'hCAFE_F00D, 1, "lw6");

        // randomized mix of bubbles, ALU ops, loads and stores
        for (int i = 0; i < 150; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'd3 | 32'($urandom_range(0, 3) & ($urandom_range(0, 1) ? 2 : 3));
            if (kind == 0)
                drive_txn(0, $urandom_range(0, 1), 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                          $urandom_range(0, 1), 5'($urandom), 5'($urandom), 2'd0, 2'd0, $urandom, 0, "bubble");
            else if (kind <= 3)
                drive_txn(1, 0, 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 1),
                          5'($urandom), 5'($urandom), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                          $urandom, 0, "alu_r");
            else if (kind <= 6)
                drive_txn(1, 1, 0, 3'($urandom_range(0, 7)), a, $urandom, $urandom, 1, 5'($urandom),
                          5'($urandom), 2'd1, 2'd1, $urandom, $urandom_range(0, 3), "load_r");
            else
                drive_txn(1, 0, 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom, 0, 5'($urandom),
                          5'($urandom), 2'd0, 2'd0, $urandom, $urandom_range(0, 3), "store_r");
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain", 128'(exp_q.size() + bus_q.size() + delay_q.size()), 128'(0));

        // reset in the second BUSY cycle of a LW, then a late ack
        slave_en = 1'b0;
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_mem_op = 3'd4;
        in_alu_result = 32'h80; in_reg_write = 1'b1;
        @(negedge clk);
        chk("t5_req_busy", 128'({dmem_req, dmem_be}), 128'({1'b1, 4'b1111}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_req_reset", 128'({dmem_req, out_valid, state_dbg}), 128'(0));
        rst = 1'b1; in_valid = 1'b0; late_ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_late_ack", 128'({dmem_req, out_valid, out_reg_write, state_dbg}), 128'(0));
        late_ack = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
